// File: rtl/t_demux_1x12_loader_pkg.sv
// Shared constants, FSM encoding and pointer helper for the 12-slot byte loader.
package t_demux_1x12_loader_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned N_SLOTS = 12;

    localparam logic [3:0] LAST_SLOT = 4'hb;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    // Auto-increment pointer: 11 wraps back to 0.
    function automatic logic [3:0] next_ptr(input logic [3:0] p);
        return (p == LAST_SLOT) ? 4'd0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/t_demux_1x12_loader_slot.sv
// One slot of the bank: a byte register with synchronous reset/clear and write-enable.
module t_slot_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (we_i) begin
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/t_demux_1x12_loader.sv
// Loads a 12 x byte slot bank from a valid/ready byte stream, in auto-increment or addressed mode.
module t_demux_1x12_loader #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_SLOTS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      addr_mode,
    input  logic [3:0]                wr_addr,
    output logic [N_SLOTS*DATA_W-1:0] slots,
    output logic [N_SLOTS-1:0]        slot_written,
    output logic [3:0]                ptr,
    output logic                      frame_done,
    output logic                      addr_err
);
    import t_demux_1x12_loader_pkg::*;

    state_e             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [N_SLOTS-1:0] written_q, written_d;
    logic               frame_done_q, frame_done_d;
    logic               addr_err_q, addr_err_d;

    logic               accept;
    logic               tgt_ok;
    logic [3:0]         tgt;
    logic [N_SLOTS-1:0] slot_we;

    // A reset/clear cycle never accepts, so the concurrent write is silently dropped.
    assign wr_ready = (state_q != StDone) && !reset && !clear;
    assign accept   = wr_valid && wr_ready;
    assign tgt      = addr_mode ? wr_addr : ptr_q;
    assign tgt_ok   = (tgt <= LAST_SLOT);

    always_comb begin
        slot_we = '0;
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            slot_we[k] = accept && tgt_ok && (tgt == 4'(k));
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        written_d    = written_q | slot_we;
        frame_done_d = 1'b0;
        addr_err_d   = accept && !tgt_ok;
        unique case (state_q)
            StIdle, StLoad: begin
                if (accept && tgt_ok) begin
                    state_d = StLoad;
                    if (!addr_mode) begin
                        ptr_d = next_ptr(ptr_q);
                        if (ptr_q == LAST_SLOT) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            written_q    <= '0;
            frame_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            written_q    <= written_d;
            frame_done_q <= frame_done_d;
            addr_err_q   <= addr_err_d;
        end
    end

    for (genvar k = 0; k < int'(N_SLOTS); k++) begin : g_slot
        t_slot_reg #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .we_i     (slot_we[k]),
            .wr_data_i(wr_data),
            .q_o      (slots[k*DATA_W +: DATA_W])
        );
    end

    assign slot_written = written_q;
    assign ptr          = ptr_q;
    assign frame_done   = frame_done_q && !reset && !clear;
    assign addr_err     = addr_err_q && !reset && !clear;

endmodule

// File: tb/tb_t_demux_1x12_loader.sv
// Directed plus randomized bench for the 12-slot loader against a behavioural slot-bank model.
module tb_t_demux_1x12_loader;

    logic        clk = 1'b0;
    logic        reset, clear, wr_valid, wr_ready, addr_mode;
    logic [7:0]  wr_data;
    logic [3:0]  wr_addr, ptr;
    logic [95:0] slots;
    logic [11:0] slot_written;
    logic        frame_done, addr_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the bank
    logic [7:0]  m_slot [12];
    logic [11:0] m_written;
    int          m_ptr;
    bit          m_done, m_fd, m_ae;

    always #5 clk = ~clk;

    t_demux_1x12_loader dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .addr_mode   (addr_mode),
        .wr_addr     (wr_addr),
        .slots       (slots),
        .slot_written(slot_written),
        .ptr         (ptr),
        .frame_done  (frame_done),
        .addr_err    (addr_err)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] model_bank();
        logic [95:0] v;
        for (int k = 0; k < 12; k++) v[k*8 +: 8] = m_slot[k];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 12; k++) m_slot[k] = 8'h00;
        m_written = '0;
        m_ptr     = 0;
        m_done    = 0;
        m_fd      = 0;
        m_ae      = 0;
    endtask

    // One clock: check ready before the edge, advance model, check registered outputs after.
    task automatic cycle();
        bit rdy;
        #1;
        rdy = !m_done && !reset && !clear;
        chk("wr_ready", {95'd0, wr_ready}, {95'd0, rdy});
        @(posedge clk);
        if (reset || clear) begin
            model_clear();
        end else begin
            m_fd = 0;
            m_ae = 0;
            if (m_done) begin
                m_done = 0;
            end else if (wr_valid) begin
                if (addr_mode) begin
                    if (wr_addr < 12) begin
                        m_slot[wr_addr]    = wr_data;
                        m_written[wr_addr] = 1'b1;
                    end else begin
                        m_ae = 1;
                    end
                end else begin
                    m_slot[m_ptr]    = wr_data;
                    m_written[m_ptr] = 1'b1;
                    if (m_ptr == 11) begin
                        m_ptr  = 0;
                        m_done = 1;
                        m_fd   = 1;
                    end else begin
                        m_ptr++;
                    end
                end
            end
        end
        #1;
        chk("slots", slots, model_bank());
        chk("slot_written", {84'd0, slot_written}, {84'd0, m_written});
        chk("ptr", {92'd0, ptr}, 96'(m_ptr));
        chk("frame_done", {95'd0, frame_done}, {95'd0, m_fd});
        chk("addr_err", {95'd0, addr_err}, {95'd0, m_ae});
        chk("pulse_excl", {95'd0, frame_done && addr_err}, 96'd0);
    endtask

    task automatic drive(input bit v, input bit mode, input logic [3:0] a, input logic [7:0] d);
        wr_valid  = v;
        addr_mode = mode;
        wr_addr   = a;
        wr_data   = d;
    endtask

    initial begin
        logic [95:0] exp_frame;
        model_clear();
        reset = 1'b1;
        clear = 1'b0;
        drive(0, 0, 4'd0, 8'd0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("reset_slots", slots, 96'd0);

        // Full auto frame 0x10..0x1B back-to-back
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 4'd0, 8'(8'h10 + k));
            cycle();
        end
        chk("frame_done_after_12", {95'd0, frame_done}, 96'd1);
        drive(0, 0, 4'd0, 8'd0);
        #1;
        chk("ready_low_in_done", {95'd0, wr_ready}, 96'd0);
        for (int k = 0; k < 12; k++) exp_frame[k*8 +: 8] = 8'(8'h10 + k);
        chk("frame_slots", slots, exp_frame);
        chk("frame_written", {84'd0, slot_written}, {84'd0, 12'hfff});
        chk("frame_ptr", {92'd0, ptr}, 96'd0);
        cycle();
        chk("done_one_cycle", {95'd0, frame_done}, 96'd0);

        // Addressed single-slot update
        drive(1, 1, 4'd7, 8'ha5);
        cycle();
        exp_frame[63:56] = 8'ha5;
        chk("addr_slot7", slots, exp_frame);
        chk("addr_ptr_kept", {92'd0, ptr}, 96'd0);

        // Out-of-range address
        drive(1, 1, 4'hc, 8'h55);
        cycle();
        chk("addr_err_pulse", {95'd0, addr_err}, 96'd1);
        chk("addr_err_slots", slots, exp_frame);
        drive(0, 0, 4'd0, 8'd0);
        cycle();
        chk("addr_err_cleared", {95'd0, addr_err}, 96'd0);

        // Partial frame, then clear alongside a write
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 4'd0, 8'(8'h30 + k));
            cycle();
        end
        clear = 1'b1;
        drive(1, 0, 4'd0, 8'h99);
        cycle();
        clear = 1'b0;
        chk("clear_slots", slots, 96'd0);
        chk("clear_ptr", {92'd0, ptr}, 96'd0);
        drive(1, 0, 4'd0, 8'h42);
        cycle();
        chk("post_clear_slot0", {88'd0, slots[7:0]}, 96'h42);

        // Finish frame, then hold a write across the DONE bubble
        for (int k = 1; k < 12; k++) begin
            drive(1, 0, 4'd0, 8'(8'h50 + k));
            cycle();
        end
        drive(1, 0, 4'd0, 8'h77);
        cycle();
        cycle();
        chk("held_write_slot0", {88'd0, slots[7:0]}, 96'h77);
        chk("held_write_ptr", {92'd0, ptr}, 96'd1);

        // Reset mid-frame with a pending write
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 4'd0, 8'(8'h60 + k));
            cycle();
        end
        reset = 1'b1;
        drive(1, 0, 4'd0, 8'hee);
        cycle();
        reset = 1'b0;
        drive(0, 0, 4'd0, 8'd0);
        chk("midreset_slots", slots, 96'd0);
        chk("midreset_written", {84'd0, slot_written}, 96'd0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            clear = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), 8'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_demux_1x12_loader.md
Name: t_demux_1x12_loader

Overview:
- Write-side counterpart of the 12-slot byte select path: loads a 12-entry x 8-bit slot bank from a byte stream; the downstream 12:1 select reads the slots.
- Two load modes:
  - auto-increment write pointer, for whole-frame loads;
  - explicit slot address, for single-slot updates.
- Adds a valid/ready handshake, frame-complete and error pulses, and a per-slot written bitmap.

Parameters:
- DATA_W, 8, width of each slot and of wr_data
- N_SLOTS, 12, number of slots. Fixed at 12 for this revision; the pointer is 4 bits.

Ports:
- clk  in  1  system clock; rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of bank, pointer, bitmap and FSM
- wr_valid  in  1  write request
- wr_ready  out  1  block accepts a write this cycle; a write occurs when wr_valid && wr_ready
- wr_data  in  DATA_W  byte to store
- addr_mode  in  1  0 = auto-increment pointer, 1 = use wr_addr
- wr_addr  in  4  target slot when addr_mode=1
- slots  out  N_SLOTS*DATA_W  slot k at bits [8k+7:8k]; registered
- slot_written  out  N_SLOTS  bit k set once slot k has been written since reset/clear
- ptr  out  4  current auto-increment pointer
- frame_done  out  1  one-cycle pulse after slot 11 is written in auto mode
- addr_err  out  1  one-cycle pulse when an addressed write targets slot 12..15

Behaviour:
- Reset (reset=1) and clear=1 are identical:
  - slots=0, slot_written=0, ptr=0
  - frame_done=0, addr_err=0, wr_ready=0 during the asserted cycle
  - state=IDLE
- reset takes priority over clear. clear takes priority over any write in the same cycle; that write is dropped with no error.
- FSM states:
  - IDLE: wr_ready=1. First accepted write goes to LOAD.
  - LOAD: wr_ready=1. An accepted auto-mode write to slot 11 goes to DONE.
  - DONE: exactly one cycle. wr_ready=0, frame_done=1, ptr=0. Then returns to IDLE.
- Auto mode (addr_mode=0), accepted write:
  - slots[ptr] <= wr_data next edge; slot_written[ptr] <= 1
  - ptr increments; 11 wraps to 0
  - registered write latency 1 cycle: data is visible on slots the cycle after the handshake
- Addressed mode (addr_mode=1), accepted write:
  - wr_addr 0..11: slots[wr_addr] <= wr_data; slot_written set; ptr unchanged; never triggers DONE
  - wr_addr 12..15: write dropped, no state change, addr_err=1 the next cycle
- wr_valid while wr_ready=0 (DONE, or a reset/clear cycle): write is not accepted. The source must hold it; it is accepted in IDLE the following cycle.
- Back-to-back writes in consecutive cycles are supported at 1 byte/cycle except for the single DONE bubble. A 12-byte frame takes 12 accept cycles + 1 DONE cycle.
- Mixed modes within a frame are allowed. Addressed writes neither advance nor reset ptr, and may overwrite slots the auto stream will later write again.
- frame_done and addr_err are registered single-cycle pulses, low otherwise. They can never both be high in the same cycle.
- slots holds its value indefinitely between writes. There is no combinational path from wr_data to slots.

Decomposition:
- Shared package holds:
  - DATA_W, N_SLOTS
  - LAST_SLOT = 4'hb
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2
- One natural sub-module: t_slot_reg, a single 8-bit register with sync reset/clear and a write-enable, instantiated 12 times from a decoded one-hot enable.
- FSM, pointer and error logic stay in the top.

Test Plan:
- Reset then 12 auto writes 0x10..0x1B back-to-back:
  - slots[k]=0x10+k
  - frame_done high exactly 1 cycle after the 12th accept; wr_ready low that cycle
  - ptr=0; slot_written=12'hFFF
- Addressed write 0xA5 to slot 7 after a full frame: only slot 7 changes; ptr stays 0; no frame_done.
- Addressed write to wr_addr=4'hC with data 0x55: all slots unchanged; addr_err pulses 1 cycle; slot_written unchanged.
- 5 auto writes, then clear held 1 cycle together with wr_valid:
  - all slots 0, ptr=0, slot_written=0
  - the concurrent write is dropped
  - the next auto write lands in slot 0
- Hold wr_valid high continuously across the DONE cycle with data 0x77: not accepted during DONE; accepted the next cycle into slot 0.
- Reset asserted mid-frame after 6 writes, with wr_valid high: identical to power-on state; no frame_done or addr_err pulse.
